// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_IR           = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage1_fetch_if.sv
// Instruction-memory request/grant/response bus between fetch and memory.
interface stage1_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_buffer.sv
// Small circular FIFO of fetched entries; head is visible combinationally.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/stage1_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers
// in-order responses and feeds decode, with stall and redirect handling.
module stage1_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hazard,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    stage1_fetch_if.master        imem,
    output logic [31:0]           if_id_ir,
    output logic [31:0]           if_id_npc
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic [31:0]      pc_r;
    logic [31:0]      resp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [31:0]      ir_r;
    logic [31:0]      npc_r;

    fetch_entry_t     buf_head_s;
    fetch_entry_t     entry_s;
    fetch_entry_t     if_id_nxt_s;
    logic [CNT_W-1:0] buf_count_s;
    logic             buf_empty_s;
    logic             buf_full_s;
    logic             buf_push_s;
    logic             buf_pop_s;
    logic             rsp_s;
    logic             keep_s;
    logic             credit_s;
    logic             req_s;
    logic             fire_s;

    // Stray responses (nothing outstanding) are ignored entirely.
    assign rsp_s    = imem.rvalid && (outstanding_r != {CNT_W{1'b0}});
    assign keep_s   = rsp_s && (drop_cnt_r == {CNT_W{1'b0}}) && !redirect_valid;
    assign credit_s = (({1'b0, outstanding_r} + {1'b0, buf_count_s}) < (CNT_W + 1)'(BUF_DEPTH));
    assign req_s    = !reset && !redirect_valid && credit_s;
    assign fire_s   = req_s && imem.gnt;
    assign entry_s  = '{ir: imem.rdata, npc: next_pc(resp_pc_r)};

    assign imem.req  = req_s;
    assign imem.addr = pc_r;
    assign if_id_ir  = ir_r;
    assign if_id_npc = npc_r;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst       (reset),
        .push      (buf_push_s),
        .push_data (entry_s),
        .pop       (buf_pop_s),
        .flush     (redirect_valid),
        .head      (buf_head_s),
        .count     (buf_count_s),
        .empty     (buf_empty_s),
        .full      (buf_full_s)
    );

    // Output select: redirect flush, then stall-hold, then head / bypass / bubble.
    always_comb begin
        buf_push_s  = 1'b0;
        buf_pop_s   = 1'b0;
        if_id_nxt_s = '{ir: ir_r, npc: npc_r};
        if (redirect_valid) begin
            if_id_nxt_s = '{ir: NOP_IR, npc: 32'h0000_0000};
        end else if (hazard) begin
            buf_push_s = keep_s;
        end else if (!buf_empty_s) begin
            buf_pop_s   = 1'b1;
            buf_push_s  = keep_s;
            if_id_nxt_s = buf_head_s;
        end else if (keep_s) begin
            if_id_nxt_s = entry_s;
        end else begin
            if_id_nxt_s = '{ir: NOP_IR, npc: 32'h0000_0000};
        end
    end

    // PC, response tracking and the registered decode interface.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            drop_cnt_r    <= {CNT_W{1'b0}};
            ir_r          <= NOP_IR;
            npc_r         <= 32'h0000_0000;
        end else begin
            ir_r  <= if_id_nxt_s.ir;
            npc_r <= if_id_nxt_s.npc;
            case ({fire_s, rsp_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (redirect_valid) begin
                pc_r       <= align_pc(redirect_pc);
                resp_pc_r  <= align_pc(redirect_pc);
                // Everything still in flight after this cycle belongs to the old path.
                drop_cnt_r <= outstanding_r - CNT_W'(rsp_s);
            end else begin
                if (fire_s) pc_r <= next_pc(pc_r);
                if (keep_s) resp_pc_r <= next_pc(resp_pc_r);
                if (rsp_s && (drop_cnt_r != {CNT_W{1'b0}}))
                    drop_cnt_r <= drop_cnt_r - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stage1_fetch.sv
// Randomised bench for stage1_fetch against a transaction-level fetch model.
module tb_stage1_fetch;

    localparam int BUF_DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        bit          live;
    } pend_t;

    logic        clk;
    logic        reset;
    logic        hazard;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;

    stage1_fetch_if imem();

    stage1_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .hazard         (hazard),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_id_ir       (if_id_ir),
        .if_id_npc      (if_id_npc)
    );

    int tests = 0;
    int fails = 0;

    // Model state: requests in flight at memory, live fetch addresses owed to
    // decode in program order, and responses received but not yet delivered.
    pend_t       pend[$];
    logic [31:0] expq[$];
    int          avail;
    logic [31:0] m_pc;
    logic [31:0] prev_ir;
    logic [31:0] prev_npc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        else if (a == 32'h0000_0004) return 32'h00A0_0113;
        else return {a[31:2], 2'b11} ^ 32'h1357_9BD0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        expq.delete();
        avail    = 0;
        m_pc     = 32'h0000_0000;
        prev_ir  = 32'h0000_0000;
        prev_npc = 32'h0000_0000;
    endtask

    // rv: 0 = no response, 1 = return oldest pending, 2 = as 1 but stray if none pending.
    task automatic step(input bit hz, input bit rd, input logic [31:0] rpc, input bit g, input int rv);
        bit          exp_req;
        bit          rv_drv;
        bit          got_live;
        pend_t       got;
        logic [31:0] e_ir;
        logic [31:0] e_npc;
        logic [31:0] a;
        @(negedge clk);
        hazard         = hz;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem.gnt       = g;
        rv_drv = (rv != 0) && (pend.size() > 0);
        if (rv_drv) begin
            imem.rvalid = 1'b1;
            imem.rdata  = mem_word(pend[0].addr);
        end else if (rv == 2) begin
            imem.rvalid = 1'b1;
            imem.rdata  = 32'hDEAD_BEEF;
        end else begin
            imem.rvalid = 1'b0;
            imem.rdata  = $urandom;
        end
        #1;
        exp_req = !rd && ((pend.size() + avail) < BUF_DEPTH);
        chk("imem_req", {31'b0, imem.req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem.addr, m_pc);
        @(posedge clk);
        #1;
        got_live = 1'b0;
        if (rv_drv) begin
            got      = pend.pop_front();
            got_live = got.live;
        end
        if (rd) begin
            foreach (pend[i]) pend[i].live = 1'b0;
            expq.delete();
            avail = 0;
            m_pc  = {rpc[31:2], 2'b00};
            e_ir  = 32'h0000_0000;
            e_npc = 32'h0000_0000;
        end else begin
            if (got_live) avail++;
            if (hz) begin
                e_ir  = prev_ir;
                e_npc = prev_npc;
            end else if (avail > 0) begin
                a     = expq.pop_front();
                e_ir  = mem_word(a);
                e_npc = a + 32'd4;
                avail--;
            end else begin
                e_ir  = 32'h0000_0000;
                e_npc = 32'h0000_0000;
            end
            if (exp_req && g) begin
                pend.push_back('{addr: m_pc, live: 1'b1});
                expq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        chk("if_id_ir", if_id_ir, e_ir);
        chk("if_id_npc", if_id_npc, e_npc);
        prev_ir  = e_ir;
        prev_npc = e_npc;
    endtask

    initial begin
        reset          = 1'b1;
        hazard         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        imem.gnt       = 1'b0;
        imem.rvalid    = 1'b0;
        imem.rdata     = 32'h0000_0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir", if_id_ir, 32'h0000_0000);
        chk("rst_npc", if_id_npc, 32'h0000_0000);
        chk("rst_req", {31'b0, imem.req}, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back fetch with one-cycle response latency.
        step(1'b0, 1'b0, 32'h0, 1'b1, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("first_ir", if_id_ir, 32'h0050_0093);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("second_npc", if_id_npc, 32'h0000_0008);

        // Grant withheld: request held at 0xC, decode sees bubbles.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 0);
        chk("stall_bubble", if_id_ir, 32'h0000_0000);

        // Hazard while responses fill the buffer, then release.
        step(1'b1, 1'b0, 32'h0, 1'b1, 0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 0);

        // Stray response with nothing outstanding must change nothing.
        step(1'b0, 1'b0, 32'h0, 1'b0, 2);
        step(1'b0, 1'b0, 32'h0, 1'b0, 0);

        // Redirect with two requests in flight; their responses are dropped.
        step(1'b0, 1'b0, 32'h0, 1'b1, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 0);
        chk("redir_addr", imem.addr, 32'h0000_0100);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1);

        // Misaligned target, and redirect beating hazard.
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0, 0);
        chk("align_addr", imem.addr, 32'h0000_0100);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1);
        chk("redir_hz_addr", imem.addr, 32'h0000_0200);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), $urandom,
                 ($urandom_range(0, 2) != 0), int'($urandom_range(0, 2)));
        end

        // Fill the buffer behind a valid if_id, then reset asynchronously.
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ir", if_id_ir, 32'h0000_0000);
        chk("arst_npc", if_id_npc, 32'h0000_0000);
        chk("arst_req", {31'b0, imem.req}, 32'h0000_0000);
        hazard         = 1'b0;
        redirect_valid = 1'b0;
        imem.gnt       = 1'b0;
        imem.rvalid    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        chk("post_rst_ir", if_id_ir, 32'h0050_0093);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage1_fetch.md
Name: stage1_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage and drives its if_id_ir / if_id_npc inputs.
- Owns the PC and issues in-order requests on the instruction-memory req/gnt/rvalid interface.
- Buffers returned instructions in a small FIFO, honours decode's hazard stall, and flushes on a redirect from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset
BUF_DEPTH, 2, fetch-buffer entries; also the maximum number of outstanding requests

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
hazard  in  1  decode stall; hold if_id outputs
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  32  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (current PC)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid, returned in order
imem_rdata  in  32  instruction word
if_id_ir  out  32  instruction to decode; 0 = bubble
if_id_npc  out  32  fetch address of if_id_ir + 4

Behaviour:
- Reset (async, active-high): pc=RESET_PC, resp_pc=RESET_PC, buffer empty, outstanding=0, drop_cnt=0, if_id_ir=0, if_id_npc=0. imem_req stays 0 while reset is high.
- Request issue:
  - imem_req = !reset && !redirect_valid && (outstanding + buf_count < BUF_DEPTH).
  - imem_addr = pc.
  - On req&gnt: pc <= pc+4 (wraps mod 2^32) and outstanding++.
  - imem_req and imem_addr hold stable until gnt.
- Response:
  - On rvalid with drop_cnt>0: discard the data and decrement drop_cnt.
  - On rvalid with drop_cnt=0: the entry is {imem_rdata, resp_pc+4}, and resp_pc <= resp_pc+4.
  - Every rvalid decrements outstanding.
  - An rvalid with outstanding=0 is a protocol error; ignore it and change no state.
- Output (priority order):
  1. redirect_valid:
     - pc <= {redirect_pc[31:2],2'b00}; resp_pc <= same.
     - Flush the buffer; if_id_ir <= 0; if_id_npc <= 0.
     - drop_cnt <= outstanding after this cycle's rvalid is accounted for. The same-cycle rvalid is discarded.
     - Redirect overrides hazard.
  2. hazard: if_id_ir and if_id_npc hold. Responses still fill the buffer.
  3. Otherwise, load if_id from the oldest valid entry:
     - If the buffer is non-empty, pop its head.
     - If the buffer is empty and an accepted rvalid arrives, bypass it straight to if_id (0-cycle buffer latency).
     - If neither, if_id_ir <= 0 and if_id_npc <= 0 (bubble).
- Latency: gnt in cycle N, rvalid in cycle M≥N+1 → if_id valid after the edge that ends cycle M, when the buffer is empty and there is no hazard.
- Overflow cannot occur: the credit rule bounds outstanding + buf_count ≤ BUF_DEPTH.
- Simultaneous push and pop in one cycle: legal; buf_count is unchanged.
- A reset asserted mid-transaction drops all in-flight state. Memory responses to pre-reset requests are the environment's responsibility; the bench must not return them.

Decomposition:
- Package fetch_pkg:
  - INSTR_BYTES=4
  - NOP_IR=32'h0
  - default RESET_PC
  - fetch_entry_t struct {ir, npc}
- Sub-module fetch_buffer: parameterised BUF_DEPTH FIFO of fetch_entry_t with push, pop, flush, count, empty and full. It supplies head data combinationally for the bypass/pop mux.

Test Plan:
- Reset, then gnt every cycle and rvalid one cycle later with rdata 0x00500093, 0x00A00113 → imem_addr 0x0, 0x4. if_id_ir/npc = 0x00500093/0x4, then 0x00A00113/0x8.
- Hold gnt low for 3 cycles → imem_req=1 with imem_addr stable at 0x8; if_id_ir=0 bubbles.
- hazard high 4 cycles while 2 responses return → if_id holds its value. imem_req drops when outstanding+count=2. On release, buffered entries emerge on consecutive cycles.
- redirect_valid with redirect_pc=0x100 while 2 requests are outstanding → next imem_addr=0x100; if_id_ir=0. Both stale rvalids are discarded. The first new if_id_npc=0x104.
- redirect_pc=0x103 → imem_addr=0x100.
- Redirect and hazard in the same cycle → flush wins: if_id_ir=0 and pc=target.
- Async reset asserted mid-cycle with a full buffer → outputs go to 0 immediately, without waiting for a clock edge; imem_req=0; the next fetch after release is at 0x0.
